// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the two-port Data_Memory arbiter: FSM states, port ids, default widths.
package data_memory_arbiter_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } arbState_t;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   localparam int DEF_WORDSIZE = 64;
   localparam int DEF_ADDR_W   = 5;

endpackage

// File: rtl/data_memory_arbiter_rr_arbiter_2.sv
// Combinational two-way pick between ports A and B.
// DMEM_ARB_FIXED_PRIO_EN selects fixed A-first priority and removes the last-served input.
module rr_arbiter_2
   import data_memory_arbiter_pkg::*;
(
`ifndef DMEM_ARB_FIXED_PRIO_EN
   input  logic last_i,
`endif
   input  logic eligA_i,
   input  logic eligB_i,
   output logic grantValid_o,
   output logic grantId_o
);

   always_comb begin
      grantValid_o = eligA_i | eligB_i;
`ifdef DMEM_ARB_FIXED_PRIO_EN
      grantId_o = eligA_i ? PORT_A : PORT_B;
`else
      // On a tie the port that was not served most recently goes first
      if (eligA_i && eligB_i) begin
         grantId_o = (last_i == PORT_A) ? PORT_B : PORT_A;
      end else begin
         grantId_o = eligA_i ? PORT_A : PORT_B;
      end
`endif
   end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares the single-port Data_Memory between port A and port B, one access at a time.
// Define DMEM_ARB_FIXED_PRIO_EN for fixed A-first priority instead of round-robin.
module data_memory_arbiter
   import data_memory_arbiter_pkg::*;
#(
   parameter int WORDSIZE = DEF_WORDSIZE,
   parameter int ADDR_W   = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                a_req,
   input  logic                a_we,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [WORDSIZE-1:0] a_wdata,
   input  logic                b_req,
   input  logic                b_we,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [WORDSIZE-1:0] b_wdata,
   output logic                a_ack,
   output logic [WORDSIZE-1:0] a_rdata,
   output logic                b_ack,
   output logic [WORDSIZE-1:0] b_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [WORDSIZE-1:0] mem_data_input,
   output logic                mem_write_enable,
   output logic                mem_read,
   input  logic [WORDSIZE-1:0] mem_read_data,
   output logic                busy
);

   arbState_t             state_q, state_d;
   logic                  we_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [WORDSIZE-1:0]   wdata_q;
   logic                  winner_q;
   logic                  a_ack_q, b_ack_q;
   logic [WORDSIZE-1:0]   a_rdata_q, b_rdata_q;

   logic                  eligA, eligB;
   logic                  grantValid, grantId;
   logic                  capture;

   // A request seen during its own ack cycle is the old one still held high
   assign eligA   = a_req & ~a_ack_q;
   assign eligB   = b_req & ~b_ack_q;
   assign capture = (state_q == IDLE) && grantValid;

`ifdef DMEM_ARB_FIXED_PRIO_EN
   rr_arbiter_2 u_rr_arbiter_2 (
      .eligA_i      (eligA),
      .eligB_i      (eligB),
      .grantValid_o (grantValid),
      .grantId_o    (grantId)
   );
`else
   logic last_q;

   rr_arbiter_2 u_rr_arbiter_2 (
      .last_i       (last_q),
      .eligA_i      (eligA),
      .eligB_i      (eligB),
      .grantValid_o (grantValid),
      .grantId_o    (grantId)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= PORT_B;
      end else if (state_q == ACCESS) begin
         last_q <= winner_q;
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grantValid) state_d = ACCESS;
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Memory strobes are decoded from the state so a reset mid-access drops them at once
   always_comb begin
      busy             = (state_q == ACCESS);
      mem_write_enable = busy & we_q;
      mem_read         = busy & ~we_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         winner_q  <= PORT_A;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         a_ack_q <= 1'b0;
         b_ack_q <= 1'b0;
         if (capture) begin
            winner_q <= grantId;
            if (grantId == PORT_A) begin
               we_q    <= a_we;
               addr_q  <= a_addr;
               wdata_q <= a_wdata;
            end else begin
               we_q    <= b_we;
               addr_q  <= b_addr;
               wdata_q <= b_wdata;
            end
         end
         if (state_q == ACCESS) begin
            if (winner_q == PORT_A) begin
               a_ack_q <= 1'b1;
               if (!we_q) a_rdata_q <= mem_read_data;
            end else begin
               b_ack_q <= 1'b1;
               if (!we_q) b_rdata_q <= mem_read_data;
            end
         end
      end
   end

   assign a_ack          = a_ack_q;
   assign b_ack          = b_ack_q;
   assign a_rdata        = a_rdata_q;
   assign b_rdata        = b_rdata_q;
   assign mem_addr       = addr_q;
   assign mem_data_input = wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed self-checking bench for data_memory_arbiter (default round-robin build) with a Data_Memory model.
module tb_data_memory_arbiter;

   localparam int WS = 64;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [WS-1:0] a_wdata, b_wdata;
   logic          a_ack, b_ack;
   logic [WS-1:0] a_rdata, b_rdata;
   logic [AW-1:0] mem_addr;
   logic [WS-1:0] mem_data_input;
   logic          mem_write_enable, mem_read;
   logic [WS-1:0] mem_read_data;
   logic          busy;

   int checks   = 0;
   int failures = 0;

   logic [WS-1:0] memModel [32] = '{1: 64'h1111, default: 64'h0};

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_write_enable) memModel[mem_addr] <= mem_data_input;
   end
   assign mem_read_data = memModel[mem_addr];

   data_memory_arbiter #(.WORDSIZE(WS), .ADDR_W(AW)) dut (
      .clk              (clk),
      .rst              (rst),
      .a_req            (a_req),
      .a_we             (a_we),
      .a_addr           (a_addr),
      .a_wdata          (a_wdata),
      .b_req            (b_req),
      .b_we             (b_we),
      .b_addr           (b_addr),
      .b_wdata          (b_wdata),
      .a_ack            (a_ack),
      .a_rdata          (a_rdata),
      .b_ack            (b_ack),
      .b_rdata          (b_rdata),
      .mem_addr         (mem_addr),
      .mem_data_input   (mem_data_input),
      .mem_write_enable (mem_write_enable),
      .mem_read         (mem_read),
      .mem_read_data    (mem_read_data),
      .busy             (busy)
   );

   task automatic checkOutput(input string tag, input logic [WS-1:0] observed, input logic [WS-1:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic aReq, input logic aWe, input logic [AW-1:0] aAddr,
                                input logic [WS-1:0] aWdata, input logic bReq, input logic bWe,
                                input logic [AW-1:0] bAddr, input logic [WS-1:0] bWdata);
      a_req = aReq; a_we = aWe; a_addr = aAddr; a_wdata = aWdata;
      b_req = bReq; b_we = bWe; b_addr = bAddr; b_wdata = bWdata;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      int ackCount;
      int consecutive;
      logic prevAck;

      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      checkOutput("rst_a_ack", a_ack, 0);
      checkOutput("rst_b_ack", b_ack, 0);
      checkOutput("rst_a_rdata", a_rdata, 0);
      checkOutput("rst_b_rdata", b_rdata, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_data", mem_data_input, 0);
      checkOutput("rst_mem_we", mem_write_enable, 0);
      checkOutput("rst_mem_read", mem_read, 0);
      checkOutput("rst_busy", busy, 0);
      rst = 1'b0;

      // Reset in the middle of an A write to address 3
      tick();
      applyStimulus(1, 1, 3, 64'h55, 0, 0, 0, 0);
      tick();
      checkOutput("abort_busy", busy, 1);
      checkOutput("abort_we_on", mem_write_enable, 1);
      checkOutput("abort_addr", mem_addr, 3);
      rst = 1'b1;
      #1;
      checkOutput("abort_we_drop", mem_write_enable, 0);
      checkOutput("abort_busy_drop", busy, 0);
      checkOutput("abort_addr_rst", mem_addr, 0);
      checkOutput("abort_data_rst", mem_data_input, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("abort_no_ack", a_ack, 0);
      rst = 1'b0;
      tick();
      checkOutput("abort_no_ack2", a_ack, 0);
      checkOutput("abort_mem3", memModel[3], 0);

      // A write 0xDEAD to addr 7, then read it back with req held
      applyStimulus(1, 1, 7, 64'hDEAD, 0, 0, 0, 0);
      tick();
      checkOutput("wr7_we", mem_write_enable, 1);
      checkOutput("wr7_data", mem_data_input, 64'hDEAD);
      tick();
      checkOutput("wr7_ack", a_ack, 1);
      checkOutput("wr7_we_off", mem_write_enable, 0);
      checkOutput("wr7_mem", memModel[7], 64'hDEAD);
      applyStimulus(1, 0, 7, 0, 0, 0, 0, 0);
      tick();
      checkOutput("rd7_masked_ack", a_ack, 0);
      checkOutput("rd7_masked_busy", busy, 0);
      tick();
      checkOutput("rd7_busy", busy, 1);
      checkOutput("rd7_read", mem_read, 1);
      tick();
      checkOutput("rd7_ack", a_ack, 1);
      checkOutput("rd7_rdata", a_rdata, 64'hDEAD);

      // Continuous A request: one ack every 3 cycles
      ackCount = 0;
      consecutive = 0;
      prevAck = a_ack;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (a_ack) ackCount++;
         if (a_ack && prevAck) consecutive++;
         prevAck = a_ack;
      end
      checkOutput("cont_ack_count", ackCount, 3);
      checkOutput("cont_consecutive", consecutive, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Tie straight after reset: A first, B two cycles later
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1, 0, 1, 0, 1, 1, 1, 64'h1234);
      tick();
      checkOutput("tie1_read", mem_read, 1);
      checkOutput("tie1_addr", mem_addr, 1);
      tick();
      checkOutput("tie1_a_ack", a_ack, 1);
      checkOutput("tie1_b_ack_low", b_ack, 0);
      checkOutput("tie1_a_rdata", a_rdata, 64'h1111);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 64'h1234);
      tick();
      checkOutput("tie1_b_we", mem_write_enable, 1);
      tick();
      checkOutput("tie1_b_ack", b_ack, 1);
      checkOutput("tie1_a_ack_low", a_ack, 0);
      checkOutput("tie1_mem1", memModel[1], 64'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // A alone reads addr 1 so A becomes the last served port
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      tick(); tick();
      checkOutput("rd1_ack", a_ack, 1);
      checkOutput("rd1_rdata", a_rdata, 64'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();

      // Second tie: B goes first this time
      applyStimulus(1, 1, 2, 64'hAAAA, 1, 0, 1, 0);
      tick();
      checkOutput("tie2_addr_b", mem_addr, 1);
      tick();
      checkOutput("tie2_b_ack", b_ack, 1);
      checkOutput("tie2_a_ack_low", a_ack, 0);
      checkOutput("tie2_b_rdata", b_rdata, 64'h1234);
      applyStimulus(1, 1, 2, 64'hAAAA, 0, 0, 0, 0);
      tick();
      checkOutput("tie2_a_we", mem_write_enable, 1);
      checkOutput("tie2_a_addr", mem_addr, 2);
      tick();
      checkOutput("tie2_a_ack", a_ack, 1);
      checkOutput("tie2_a_rdata_hold", a_rdata, 64'h1234);
      checkOutput("tie2_mem2", memModel[2], 64'hAAAA);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("idle_addr_hold", mem_addr, 2);
      checkOutput("idle_we_low", mem_write_enable, 0);
      checkOutput("idle_read_low", mem_read, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_memory_arbiter.md
# data_memory_arbiter

Two-port arbiter and sequencer that shares the single-port `Data_Memory` between two requesters: port A (processor load/store path) and port B (debug/loader port). It accepts one transaction at a time, latches the winner's command, drives the memory for exactly one access cycle, and returns a registered acknowledge with read data. It sits between the requesters and `Data_Memory`, which it fully owns.

## Interface
- `WORDSIZE`, 64, data word width; matches `Data_Memory`.
- `ADDR_W`, 5, memory address width.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `a_req` / `b_req`  in  1  transaction request; held until ack.
- `a_we` / `b_we`  in  1  1 = write, 0 = read.
- `a_addr` / `b_addr`  in  ADDR_W  word address.
- `a_wdata` / `b_wdata`  in  WORDSIZE  write data.
- `a_ack` / `b_ack`  out  1  one-cycle completion pulse.
- `a_rdata` / `b_rdata`  out  WORDSIZE  read result; valid with ack, held after.
- `mem_addr`  out  ADDR_W  to `Data_Memory` `addr`.
- `mem_data_input`  out  WORDSIZE  to `data_input`.
- `mem_write_enable`  out  1  to `write_enable`.
- `mem_read`  out  1  to `read`.
- `mem_read_data`  in  WORDSIZE  from `read_data` (combinational).
- `busy`  out  1  high while in ACCESS.

## Operation
- States: IDLE, ACCESS. Reset state IDLE.
- IDLE: eligible requester = `x_req & ~x_ack` (a request seen during its own ack cycle is not a new request). If any eligible: pick winner, latch `we/addr/wdata` and winner id, go ACCESS. Else stay.
- Selection: one eligible wins. Both eligible: round-robin; winner is the port not served last. `last` register resets to B, so A wins the first tie.
- ACCESS (exactly one cycle): `mem_addr`/`mem_data_input` = latched values; `mem_write_enable` = latched we; `mem_read` = ~latched we. At the ending edge: write commits in memory; winner's `x_ack` <= 1; on read, `x_rdata` <= `mem_read_data`; on write, `x_rdata` holds; `last` <= winner; go IDLE.
- Outside ACCESS: `mem_write_enable` = 0, `mem_read` = 0; `mem_addr`/`mem_data_input` hold last latched values.
- Acks are one-cycle pulses; at most one ack high per cycle. Loser's inputs ignored and not latched; it keeps `req` high and is served next.
- Requester inputs may change after the capture edge; the latched copy is used.

## Timing
- Request high in IDLE cycle N -> ACCESS in N+1 -> ack high in N+2 (latency 2).
- Arbiter is IDLE again in N+2; a different port's request can be captured in N+2 -> ACCESS N+3. Throughput: one access per 2 cycles.
- Same requester: issue next request from cycle N+3 (req may stay high; it is masked during N+2 and re-evaluated in N+3).
- Reset values: state IDLE, `a_ack`=`b_ack`=0, `a_rdata`=`b_rdata`=0, `mem_addr`=0, `mem_data_input`=0, `mem_write_enable`=0, `mem_read`=0, `busy`=0, `last`=B.
- Reset asserted during ACCESS: returns to IDLE immediately, `mem_write_enable` drops asynchronously, no ack issued, write aborted.

## Configuration
- `DMEM_ARB_FIXED_PRIO_EN` defined: fixed priority, A always wins when both eligible; `last` register not implemented.
- Undefined (default): round-robin as above.

## Structure
- Shared package: state encoding (IDLE, ACCESS), port id constants (PORT_A=0, PORT_B=1), default widths.
- Sub-module `rr_arbiter_2`: combinational two-way pick from eligible bits and `last`; the FSM, latches and ack registers stay in `data_memory_arbiter`.

## Test plan
- Reset mid-ACCESS of A write 0x55 to addr 3 -> no `a_ack`, addr 3 unchanged, all outputs at reset values.
- A write 0xDEAD to addr 7 in cycle N -> `mem_write_enable`=1 in N+1 only, `a_ack`=1 in N+2; then A read addr 7 -> `a_rdata`=0xDEAD with ack.
- A and B request together from reset (A read addr 1, B write 0x1234 addr 1) -> A served first (old value), B ack two cycles later; repeat tie -> B first.
- A holds `req` continuously with B idle -> acks every 3 cycles, never two consecutive ack cycles.
- With `DMEM_ARB_FIXED_PRIO_EN`, A and B both hold `req` -> A always wins ties; B served only when A is masked during its ack cycle.
